// File: rtl/wave_mixer_pkg.sv
// Shared sample types and the 16-bit saturation helper for the wave mixing path.
package wave_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SAT_IN_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Clamp a wide signed sum into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] a);
    if (a > 32'sd32767)       return 16'sh7fff;
    else if (a < -32'sd32768) return 16'sh8000;
    else                      return a[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/wave_mixer_if.sv
// Voice input strobe and frame output valid/ready stream of the wave mixer.
interface wave_mixer_if;
  import wave_pkg::*;

  logic    in_valid;
  sample_t in_sample;
  logic    frame_sync;
  logic    out_valid;
  logic    out_ready;
  sample_t out_sample;

  modport master (
    output in_valid, in_sample, frame_sync, out_ready,
    input  out_valid, out_sample
  );
  modport slave (
    input  in_valid, in_sample, frame_sync, out_ready,
    output out_valid, out_sample
  );
endinterface

// File: rtl/wave_mixer_sample_fifo.sv
// First-word-fall-through sample FIFO; when empty the output holds the last popped word.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic [WIDTH-1:0]            last_q;
  logic                        do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/wave_mixer.sv
// Sums NUM_VOICES time-multiplexed voice results per frame into a buffered 16-bit sample.
// WAVE_MIXER_CLIP_EN selects saturating reduction and adds the clip_sticky flag.
module wave_mixer import wave_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  wave_mixer_if.slave  bus,
  output logic         ovf
`ifdef WAVE_MIXER_CLIP_EN
  , output logic       clip_sticky
`endif
);
  localparam int CW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + CW;

  logic signed [ACC_W-1:0] acc, in_ext, sum;
  logic [CW-1:0]           voice_cnt, cnt_eff;
  logic                    last;
  logic                    push_vld;
  sample_t                 push_data, red;
  logic                    fifo_full, fifo_empty, pop;

  assign in_ext  = {{(ACC_W-SAMPLE_W){bus.in_sample[SAMPLE_W-1]}}, bus.in_sample};
  // frame_sync makes a coincident strobe voice 0 of the new frame.
  assign cnt_eff = bus.frame_sync ? '0 : voice_cnt;
  assign sum     = (cnt_eff == '0) ? in_ext : acc + in_ext;
  assign last    = (cnt_eff == CW'(NUM_VOICES-1));

`ifdef WAVE_MIXER_CLIP_EN
  logic signed [SAT_IN_W-1:0] sum_wide;
  logic                       clip_hit;
  assign sum_wide = {{(SAT_IN_W-ACC_W){sum[ACC_W-1]}}, sum};
  assign red      = sat16(sum_wide);
  assign clip_hit = (sum_wide != {{(SAT_IN_W-SAMPLE_W){red[SAMPLE_W-1]}}, red});
`else
  assign red = sum[SAMPLE_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      voice_cnt <= '0;
      push_vld  <= 1'b0;
      push_data <= '0;
`ifdef WAVE_MIXER_CLIP_EN
      clip_sticky <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;
      if (bus.in_valid) begin
        acc <= sum;
        if (last) begin
          voice_cnt <= '0;
          push_vld  <= 1'b1;
          push_data <= red;
`ifdef WAVE_MIXER_CLIP_EN
          if (clip_hit) clip_sticky <= 1'b1;
`endif
        end else begin
          voice_cnt <= cnt_eff + CW'(1);
        end
      end else if (bus.frame_sync) begin
        voice_cnt <= '0;
        acc       <= '0;
      end
    end
  end

  assign pop = bus.out_valid && bus.out_ready;

  // Dropped frame: push into a full FIFO whose head is not leaving.
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= push_vld && fifo_full && !pop;
  end

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_vld),
    .din   (push_data),
    .pop   (pop),
    .dout  (bus.out_sample),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
endmodule

// File: tb/tb_wave_mixer.sv
// Randomised and directed check of wave_mixer against a frame-level queue model.
module tb_wave_mixer;
  import wave_pkg::*;

  localparam int NV = 4;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset;
  logic ovf;
`ifdef WAVE_MIXER_CLIP_EN
  logic clip_sticky;
`endif

  wave_mixer_if bus();

  wave_mixer #(.NUM_VOICES(NV), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ovf   (ovf)
`ifdef WAVE_MIXER_CLIP_EN
    , .clip_sticky (clip_sticky)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state: voices of the open frame, registered push, FIFO contents
  int frame[$];
  int mq[$];
  int pend_v, pend_d, ovf_exp, clip_exp;
  int got[$];
  int ovf_cnt;

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int reduce(int s);
`ifdef WAVE_MIXER_CLIP_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    logic signed [15:0] t;
    t = s[15:0];
    return int'(t);
`endif
  endfunction

  task automatic step(bit v, int s, bit fs, bit rdy, bit rst = 1'b0);
    bit pop;
    int sum;
    @(negedge clk);
    reset          = rst;
    bus.in_valid   = v;
    bus.in_sample  = 16'(s);
    bus.frame_sync = fs;
    bus.out_ready  = rdy;
    if (!rst && bus.out_valid && rdy) got.push_back(int'(bus.out_sample));
    if (rst) begin
      frame.delete(); mq.delete();
      pend_v = 0; ovf_exp = 0; clip_exp = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      ovf_exp = 0;
      if (pend_v != 0) begin
        if (mq.size() == FD && !pop) ovf_exp = 1;
        else mq.push_back(pend_d);
      end
      pend_v = 0;
      if (fs) frame.delete();
      if (v) begin
        frame.push_back(s);
        if (frame.size() == NV) begin
          sum = 0;
          foreach (frame[i]) sum += frame[i];
          pend_v = 1;
          pend_d = reduce(sum);
          if (pend_d != sum) clip_exp = 1;
          frame.delete();
        end
      end
    end
    @(posedge clk); #1;
    chk("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk("out_sample", int'(bus.out_sample), mq[0]);
    chk("ovf", int'(ovf), ovf_exp);
    ovf_cnt += int'(ovf);
`ifdef WAVE_MIXER_CLIP_EN
    chk("clip_sticky", int'(clip_sticky), clip_exp);
`endif
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, rdy);
  endtask

  task automatic frame4(int a, int b, int c, int d, bit rdy);
    step(1'b1, a, 1'b0, rdy);
    step(1'b1, b, 1'b0, rdy);
    step(1'b1, c, 1'b0, rdy);
    step(1'b1, d, 1'b0, rdy);
  endtask

  task automatic chk_got(string tag, int exp[$]);
    chk(tag, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_sample"}, int'(bus.out_sample), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
`ifdef WAVE_MIXER_CLIP_EN
    chk({tag, "_clip"}, int'(clip_sticky), 0);
`endif
  endtask

  initial begin
    int exp2;
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.frame_sync = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    ovf_cnt = 0;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk_reset_vals("rst");

    // basic frame and two-cycle latency
    got.delete();
    frame4(100, 200, -50, 7, 1'b1);
    idle(4, 1'b1);
    chk_got("t1_sum", '{257});

    // overflowing sum
    got.delete();
    frame4(30000, 30000, 30000, 30000, 1'b1);
    idle(3, 1'b1);
`ifdef WAVE_MIXER_CLIP_EN
    exp2 = 32767;
    chk("t2_clip", int'(clip_sticky), 1);
`else
    exp2 = -11072;
`endif
    chk_got("t2_big", '{exp2});

    // frame_sync drops a partial frame
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    got.delete();
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    frame4(1, 1, 1, 1, 1'b1);
    idle(3, 1'b1);
    chk_got("t3_sync", '{4});

    // FIFO fill and overflow
    got.delete(); ovf_cnt = 0;
    for (int k = 1; k <= 5; k++) frame4(k, 0, 0, 0, 1'b0);
    idle(3, 1'b0);
    chk("t4_ovf_cnt", ovf_cnt, 1);
    idle(6, 1'b1);
    chk_got("t4_drain", '{1, 2, 3, 4});

    // reset mid-frame
    got.delete();
    step(1'b1, 9, 1'b0, 1'b1);
    step(1'b1, 9, 1'b0, 1'b1);
    step(1'b1, 9, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk_reset_vals("t5_rst");
    frame4(10, 10, 10, 10, 1'b1);
    idle(3, 1'b1);
    chk_got("t5_after", '{40});

    // push coincident with pop on a full FIFO
    got.delete(); ovf_cnt = 0;
    for (int k = 1; k <= 4; k++) frame4(k, 0, 0, 0, 1'b0);
    idle(3, 1'b0);
    frame4(9, 0, 0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t6_valid", int'(bus.out_valid), 1);
    idle(7, 1'b1);
    chk("t6_no_ovf", ovf_cnt, 0);
    chk_got("t6_drain", '{1, 2, 3, 4, 9});

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(20000, 32767))
                                       : int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
